// File: rtl/cv32e40p_lsu_trans_tracker.sv
// LSU transaction front end: converts core load/store requests into word-aligned OBI transactions,
// bounds outstanding requests to DEPTH and formats in-order responses from a sideband FIFO.
module cv32e40p_lsu_trans_tracker #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_sign_ext_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        rsp_we_o,
   output logic        busy_o,
   output logic        trans_valid_o,
   input  logic        trans_ready_i,
   output logic [31:0] trans_addr_o,
   output logic        trans_we_o,
   output logic [3:0]  trans_be_o,
   output logic [31:0] trans_wdata_o,
   output logic [5:0]  trans_atop_o,
   input  logic        resp_valid_i,
   input  logic [31:0] resp_rdata_i,
   input  logic        resp_err_i
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   typedef struct packed {
      logic [1:0] off;
      logic [1:0] size;
      logic       sext;
      logic       we;
   } side_t;

   logic [CW-1:0] cnt_q;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   side_t         fifo_q [DEPTH];
   side_t         new_ent;
   side_t         head;
   logic          not_full;
   logic          accept;
   logic          pop;

   function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   gen_be = 4'b0001 << off;
         2'b01:   gen_be = off[1] ? 4'b1100 : 4'b0011;
         default: gen_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'b00:   gen_wdata = {4{wdata[7:0]}};
         2'b01:   gen_wdata = {2{wdata[15:0]}};
         default: gen_wdata = wdata;
      endcase
   endfunction

   // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
   function automatic logic [31:0] fmt_rdata(input side_t e, input logic [31:0] rdata);
      logic [31:0] s;
      s = rdata >> {e.off, 3'b000};
      case (e.size)
         2'b00:   fmt_rdata = {{24{e.sext & s[7]}}, s[7:0]};
         2'b01:   fmt_rdata = {{16{e.sext & s[15]}}, s[15:0]};
         default: fmt_rdata = rdata;
      endcase
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      ptr_inc = (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   assign not_full      = (cnt_q < DEPTH_C);
   assign trans_valid_o = req_valid_i && not_full;
   assign req_ready_o   = trans_ready_i && not_full;
   assign accept        = req_valid_i && req_ready_o;
   assign pop           = resp_valid_i && (cnt_q != '0);

   assign trans_addr_o  = {req_addr_i[31:2], 2'b00};
   assign trans_we_o    = req_we_i;
   assign trans_be_o    = gen_be(req_size_i, req_addr_i[1:0]);
   assign trans_wdata_o = gen_wdata(req_size_i, req_wdata_i);
   assign trans_atop_o  = '0;

   assign new_ent = '{off: req_addr_i[1:0], size: req_size_i, sext: req_sign_ext_i, we: req_we_i};
   assign head    = fifo_q[rd_ptr_q];

   assign rsp_valid_o = pop;
   assign rsp_err_o   = resp_err_i && pop;
   assign rsp_we_o    = head.we;
   assign rsp_rdata_o = (head.we || resp_err_i) ? 32'h0 : fmt_rdata(head, resp_rdata_i);
   assign busy_o      = (cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         if (accept) begin
            fifo_q[wr_ptr_q] <= new_ent;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (accept && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !accept) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_cv32e40p_lsu_trans_tracker.sv
// Bench for cv32e40p_lsu_trans_tracker: directed test-plan steps followed by random traffic
// compared against a queue-based model of outstanding transactions.
module tb_cv32e40p_lsu_trans_tracker;

   localparam int DEPTH = 2;

   logic        clk, rst_n;
   logic        req_valid_i, req_ready_o, req_we_i, req_sign_ext_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [1:0]  req_size_i;
   logic        rsp_valid_o, rsp_err_o, rsp_we_o, busy_o;
   logic [31:0] rsp_rdata_o;
   logic        trans_valid_o, trans_ready_i, trans_we_o;
   logic [31:0] trans_addr_o, trans_wdata_o;
   logic [3:0]  trans_be_o;
   logic [5:0]  trans_atop_o;
   logic        resp_valid_i, resp_err_i;
   logic [31:0] resp_rdata_i;

   cv32e40p_lsu_trans_tracker #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_we_i(req_we_i), .req_size_i(req_size_i), .req_sign_ext_i(req_sign_ext_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .rsp_we_o(rsp_we_o), .busy_o(busy_o),
      .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_addr_o(trans_addr_o),
      .trans_we_o(trans_we_o), .trans_be_o(trans_be_o), .trans_wdata_o(trans_wdata_o),
      .trans_atop_o(trans_atop_o),
      .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned off;
      int unsigned size;
      bit          sext;
      bit          we;
   } ent_t;

   ent_t q[$];
   int   errors = 0;
   int   checks = 0;
   bit   acc_r, pop_r;
   ent_t ne_r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] m_be(input int unsigned size, input int unsigned off);
      if (size == 0) return 4'(1 << off);
      if (size == 1) return (off >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input int unsigned size, input logic [31:0] w);
      if (size == 0) return (w % 256) * 32'h0101_0101;
      if (size == 1) return (w % 65536) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_fmt(input ent_t e, input logic [31:0] d, input bit err);
      logic [31:0] s, v;
      if (e.we || err) return 32'h0;
      s = d >> (8 * e.off);
      if (e.size == 0) begin
         v = s % 256;
         if (e.sext && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (e.size == 1) begin
         v = s % 65536;
         if (e.sext && v >= 32768) v = v + 32'hFFFF_0000;
      end else v = d;
      return v;
   endfunction

   // Called just after a falling edge: apply inputs, check outputs against the model.
   task automatic drive(input bit v, input logic [31:0] addr, input bit we, input logic [1:0] size,
                        input bit sext, input logic [31:0] wdata, input bit tready,
                        input bit rv, input logic [31:0] rdata, input bit rerr);
      int  cnt;
      bit  nf;
      req_valid_i = v; req_addr_i = addr; req_we_i = we; req_size_i = size;
      req_sign_ext_i = sext; req_wdata_i = wdata; trans_ready_i = tready;
      resp_valid_i = rv; resp_rdata_i = rdata; resp_err_i = rerr;
      #1;
      cnt = q.size();
      nf  = (cnt < DEPTH);
      acc_r = v && tready && nf;
      pop_r = rv && (cnt != 0);
      ne_r  = '{off: int'(addr[1:0]), size: (size == 2'b11) ? 2 : int'(size), sext: sext, we: we};
      chk("req_ready", req_ready_o, tready && nf);
      chk("trans_valid", trans_valid_o, v && nf);
      if (v) begin
         chk("trans_addr", trans_addr_o, addr & 32'hFFFF_FFFC);
         chk("trans_be", trans_be_o, m_be(ne_r.size, ne_r.off));
         chk("trans_wdata", trans_wdata_o, m_wdata(ne_r.size, wdata));
         chk("trans_we", trans_we_o, we);
      end
      chk("rsp_valid", rsp_valid_o, pop_r);
      if (pop_r) begin
         chk("rsp_rdata", rsp_rdata_o, m_fmt(q[0], rdata, rerr));
         chk("rsp_err", rsp_err_o, rerr);
         chk("rsp_we", rsp_we_o, q[0].we);
      end
      chk("busy", busy_o, cnt != 0);
      chk("atop", trans_atop_o, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (pop_r) void'(q.pop_front());
      if (acc_r) q.push_back(ne_r);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid_i = 0; req_addr_i = 0; req_we_i = 0; req_size_i = 0; req_sign_ext_i = 0;
      req_wdata_i = 0; trans_ready_i = 0; resp_valid_i = 0; resp_rdata_i = 0; resp_err_i = 0;
      @(negedge clk);
      #1;
      chk("reset_busy", busy_o, 0);
      chk("reset_rsp_valid", rsp_valid_o, 0);
      chk("reset_atop", trans_atop_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Signed byte load at offset 3
      drive(1, 32'h1003, 0, 2'b00, 1, 0, 1, 0, 0, 0);
      chk("byte_addr", trans_addr_o, 32'h1000);
      chk("byte_be", trans_be_o, 4'b1000);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h80AB_CDEF, 0);
      chk("byte_sext_rdata", rsp_rdata_o, 32'hFFFF_FF80);
      tick();
      drive(1, 32'h1003, 0, 2'b00, 0, 0, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h80AB_CDEF, 0);
      chk("byte_zext_rdata", rsp_rdata_o, 32'h0000_0080);
      tick();

      // Half store at offset 2
      drive(1, 32'h2002, 1, 2'b01, 0, 32'h1234_5678, 1, 0, 0, 0);
      chk("half_be", trans_be_o, 4'b1100);
      chk("half_wdata", trans_wdata_o, 32'h5678_5678);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 0);
      chk("store_rsp_we", rsp_we_o, 1);
      chk("store_rsp_rdata", rsp_rdata_o, 0);
      tick();

      // Back-pressure: third load stalls until a slot frees
      drive(1, 32'h10, 0, 2'b10, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 32'h14, 0, 2'b10, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 32'h18, 0, 2'b10, 0, 0, 1, 0, 0, 0);
      chk("full_ready", req_ready_o, 0);
      chk("full_busy", busy_o, 1);
      tick();
      drive(1, 32'h18, 0, 2'b10, 0, 0, 1, 1, 32'h1111_1111, 0);
      chk("full_resp_ready", req_ready_o, 0);
      tick();
      drive(1, 32'h18, 0, 2'b10, 0, 0, 1, 0, 0, 0);
      chk("freed_ready", req_ready_o, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h2222_2222, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h3333_3333, 0); tick();

      // In-order sideband
      drive(1, 32'h0, 0, 2'b10, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 32'h6, 0, 2'b01, 1, 0, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
      chk("order_word", rsp_rdata_o, 32'hDEAD_BEEF);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h8001_0000, 0);
      chk("order_half", rsp_rdata_o, 32'hFFFF_8001);
      tick();

      // Error response then spurious response
      drive(1, 32'h40, 0, 2'b10, 0, 0, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'hAAAA_5555, 1);
      chk("err_flag", rsp_err_o, 1);
      chk("err_rdata", rsp_rdata_o, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234_0000, 0);
      chk("spurious_valid", rsp_valid_o, 0);
      chk("spurious_busy", busy_o, 0);
      tick();

      // Reset with two outstanding
      drive(1, 32'h80, 0, 2'b10, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 32'h84, 0, 2'b10, 0, 0, 1, 0, 0, 0); tick();
      req_valid_i = 0; resp_valid_i = 1; trans_ready_i = 0;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("rst_busy", busy_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("post_rst_ready", req_ready_o, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA, 0);
      chk("post_rst_ready_low", req_ready_o, 0);
      chk("late_rsp_dropped", rsp_valid_o, 0);
      tick();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
               $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0),
               $urandom_range(0, 1), $urandom, ($urandom_range(0, 7) == 0));
         tick();
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cv32e40p_lsu_trans_tracker.md
# cv32e40p_lsu_trans_tracker

Core-side load/store transaction front end that feeds the OBI interface adapter's trans_* request port and consumes its resp_* response port. Converts size/offset-qualified core requests into word-aligned byte-enabled transactions, limits outstanding transactions to DEPTH, and records per-transaction sideband in an in-order FIFO. Returned read data is realigned and zero- or sign-extended.

## Interface
- DEPTH, 2: maximum outstanding transactions and sideband FIFO depth. Legal range is 1..8.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  core request accepted this cycle (when req_valid_i=1)
- req_addr_i  in  32  byte address
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00=byte, 01=half, 10=word, 11 treated as word
- req_sign_ext_i  in  1  sign-extend load data
- req_wdata_i  in  32  store data, LSB-justified
- rsp_valid_o  out  1  core response valid; consumer is always ready
- rsp_rdata_o  out  32  formatted load data
- rsp_err_o  out  1  bus error
- rsp_we_o  out  1  response belongs to a store
- busy_o  out  1  at least one transaction outstanding
- trans_valid_o  out  1  to adapter trans_valid_i
- trans_ready_i  in  1  from adapter trans_ready_o
- trans_addr_o  out  32  {req_addr_i[31:2], 2'b00}
- trans_we_o  out  1  req_we_i
- trans_be_o  out  4  byte enables
- trans_wdata_o  out  32  lane-replicated store data
- trans_atop_o  out  6  constant 0
- resp_valid_i  in  1  from adapter resp_valid_o
- resp_rdata_i  in  32  from adapter resp_rdata_o
- resp_err_i  in  1  from adapter resp_err_o

## Operation
- State consists of the outstanding counter cnt_q (0..DEPTH), FIFO wr/rd pointers, and DEPTH entries of {off[1:0], size[1:0], sext, we}.
- trans_valid_o = req_valid_i && (cnt_q < DEPTH). req_ready_o = trans_ready_i && (cnt_q < DEPTH).
- A request is accepted when req_valid_i && req_ready_o. On acceptance, the sideband entry is pushed.
- A response pops the FIFO when resp_valid_i && cnt_q != 0.
- cnt_q: +1 on accept only, -1 on pop only, unchanged when both occur or when neither occurs.
- Byte enables:
  - byte: 4'b0001 << off
  - half: off[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- Alignment is the caller's responsibility. For a misaligned half or word request, off[0] (and off[1] for words) is ignored in BE generation; no error is raised.
- Response formatting uses the FIFO head entry. s = resp_rdata_i >> (8*off).
  - byte: {24{sext & s[7]}, s[7:0]}
  - half: {16{sext & s[15]}, s[15:0]}
  - word: resp_rdata_i
- rsp_rdata_o = 0 when the head entry is a store or when resp_err_i=1.
- rsp_valid_o = resp_valid_i && cnt_q != 0. rsp_err_o = resp_err_i && rsp_valid_o. rsp_we_o = head.we.
- A spurious response (resp_valid_i while cnt_q == 0) is dropped: no rsp_valid_o, no pointer or counter change.
- busy_o = (cnt_q != 0).

## Timing
- Reset: cnt_q=0, pointers=0, entries=0. rsp_valid_o=0, busy_o=0, trans_atop_o=0.
- trans_valid_o and req_ready_o follow their inputs combinationally. No request is blocked while cnt_q < DEPTH.
- Request-to-bus latency is 0 cycles: a transaction is presented on trans_* in the same cycle as the request.
- Response latency is 0 cycles: rsp_* is combinational from resp_* plus the FIFO head.
- Full (cnt_q == DEPTH): req_ready_o=0 and trans_valid_o=0, even if a response arrives in the same cycle. The freed slot is usable next cycle.
- Simultaneous accept and response at 0 < cnt_q < DEPTH: cnt_q holds, and both pointers advance with wrap modulo DEPTH.
- Pointers wrap from DEPTH-1 to 0.
- Reset asserted mid-operation clears all outstanding state immediately. Responses arriving after reset are treated as spurious.
- No path from trans_ready_i to trans_valid_o.

## Test plan
- Byte load, signed: addr=0x1003, size=00, sext=1; response rdata=0x80AB_CDEF.
  - Required: trans_addr=0x1000, be=1000, rsp_rdata=0xFFFF_FF80.
  - Repeat with sext=0: rsp_rdata=0x0000_0080.
- Half store: addr=0x2002, size=01, wdata=0x1234_5678.
  - Required: be=1100, trans_wdata=0x5678_5678.
  - Response: rsp_we=1, rsp_rdata=0.
- DEPTH=2 back-pressure: three back-to-back loads, trans_ready_i=1, no responses.
  - Required: first two accepted, third stalls with req_ready_o=0, busy_o=1.
  - One response frees a slot; the third load is accepted the next cycle.
- In-order sideband: word load @0x0, then half load @0x6 (sext=1) outstanding.
  - Responses 0xDEAD_BEEF then 0x8001_0000.
  - Required: rsp_rdata 0xDEAD_BEEF, then 0xFFFF_8001.
- Error and spurious response: load, then resp_err_i=1.
  - Required: rsp_err=1, rsp_rdata=0, cnt_q returns to 0.
  - A further resp_valid_i at cnt_q=0 yields rsp_valid_o=0.
- Reset mid-flight: two outstanding, then rst_n low for 1 cycle.
  - Required: busy_o=0 and req_ready_o=trans_ready_i immediately after reset.
  - Late responses are dropped.
